// File: rtl/vec_sum_pipe.sv
// Pipelined signed vector reduction with valid/ready flow control and group accumulation.
// Define VEC_SUM_SAT_EN to clamp the accumulator instead of letting it wrap.
module vec_sum_pipe #(
  parameter int BIT_WIDTH  = 16,
  parameter int LENGTH     = 32,
  parameter int REG_STRIDE = 1,
  parameter int SUM_WIDTH  = BIT_WIDTH + $clog2(LENGTH),
  parameter int ACC_WIDTH  = SUM_WIDTH + 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic signed [BIT_WIDTH-1:0] i_vec [LENGTH],
  input  logic                        i_last,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [ACC_WIDTH-1:0] o_sum,
  output logic                        o_sat,
  output logic                        o_valid,
  input  logic                        i_ready
);

  localparam int D = $clog2(LENGTH);
  localparam int N = 1 << D;

  // Global stall: every register in the block advances together or not at all.
  logic adv;
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int LW = BIT_WIDTH + k;
    localparam int NW = N >> k;

    logic signed [LW-1:0] data [NW];
    logic                 vld;
    logic                 lst;

    if (k == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_lane
        if (i < LENGTH) begin : g_real
          assign data[i] = i_vec[i];
        end else begin : g_pad
          assign data[i] = '0;
        end
      end
      assign vld = i_valid;
      assign lst = i_last;
    end else begin : g_add
      logic signed [LW-1:0] sum [NW];

      for (genvar j = 0; j < NW; j++) begin : g_pair
        assign sum[j] = LW'(g_lvl[k-1].data[2*j]) + LW'(g_lvl[k-1].data[2*j+1]);
      end

      if ((k % REG_STRIDE == 0) || (k == D)) begin : g_reg
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            vld <= 1'b0;
            lst <= 1'b0;
          end else if (adv) begin
            vld <= g_lvl[k-1].vld;
            lst <= g_lvl[k-1].lst;
          end
        end

        // NOTE: datapath registers carry no reset; the stage valid bit qualifies them.
        always_ff @(posedge i_clk) begin
          if (adv) begin
            for (int j = 0; j < NW; j++) data[j] <= sum[j];
          end
        end
      end else begin : g_comb
        assign data = sum;
        assign vld  = g_lvl[k-1].vld;
        assign lst  = g_lvl[k-1].lst;
      end
    end
  end

  logic signed [SUM_WIDTH-1:0] fin;
  logic signed [ACC_WIDTH-1:0] fin_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] total;
  logic                        fin_vld;
  logic                        fin_lst;

  assign fin     = SUM_WIDTH'(g_lvl[D].data[0]);
  assign fin_ext = ACC_WIDTH'(fin);
  assign fin_vld = g_lvl[D].vld;
  assign fin_lst = g_lvl[D].lst;

`ifdef VEC_SUM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] wide;
  logic                      grp_sat;
  logic                      total_sat;

  // One guard bit exposes overflow; a group that clamped once keeps its clamped value.
  always_comb begin
    wide      = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(fin_ext);
    total     = wide[ACC_WIDTH-1:0];
    total_sat = 1'b0;
    if (grp_sat) begin
      total     = acc;
      total_sat = 1'b1;
    end else if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      total     = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      total_sat = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grp_sat <= 1'b0;
      o_sat   <= 1'b0;
    end else if (adv && fin_vld) begin
      grp_sat <= total_sat && !fin_lst;
      if (fin_lst) o_sat <= total_sat;
    end
  end
`else
  assign total = acc + fin_ext;
  assign o_sat = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      o_sum   <= '0;
      o_valid <= 1'b0;
    end else if (adv) begin
      o_valid <= fin_vld && fin_lst;
      if (fin_vld) begin
        if (fin_lst) begin
          o_sum <= total;
          acc   <= '0;
        end else begin
          acc <= total;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_sum_pipe.sv
// Self-checking bench for vec_sum_pipe: scoreboard model on the main instance plus directed
// cases on a narrow-accumulator instance and a non-power-of-two instance.
module tb_vec_sum_pipe;

  localparam int ACC_W = 21;  // 8 + $clog2(32) + 8
  localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: 32 x 8-bit, stride 1, default accumulator width
  logic signed [7:0]       m_vec [32];
  logic                    m_last = 1'b0, m_ivalid = 1'b0, m_irdy = 1'b1;
  logic                    m_ordy, m_sat, m_ovalid;
  logic signed [ACC_W-1:0] m_sum;

  // narrow instance: 32 x 8-bit, 14-bit accumulator
  logic signed [7:0]  n_vec [32];
  logic               n_last = 1'b0, n_ivalid = 1'b0, n_irdy = 1'b1;
  logic               n_ordy, n_sat, n_ovalid;
  logic signed [13:0] n_sum;

  // odd instance: 5 x 8-bit, stride 2
  logic signed [7:0]  q_vec [5];
  logic               q_last = 1'b0, q_ivalid = 1'b0, q_irdy = 1'b1;
  logic               q_ordy, q_sat, q_ovalid;
  logic signed [18:0] q_sum;

  vec_sum_pipe #(.BIT_WIDTH(8), .LENGTH(32), .REG_STRIDE(1)) u_main (
    .i_clk(clk), .i_rst_n(rst_n), .i_vec(m_vec), .i_last(m_last), .i_valid(m_ivalid),
    .o_ready(m_ordy), .o_sum(m_sum), .o_sat(m_sat), .o_valid(m_ovalid), .i_ready(m_irdy));

  vec_sum_pipe #(.BIT_WIDTH(8), .LENGTH(32), .REG_STRIDE(1), .ACC_WIDTH(14)) u_narrow (
    .i_clk(clk), .i_rst_n(rst_n), .i_vec(n_vec), .i_last(n_last), .i_valid(n_ivalid),
    .o_ready(n_ordy), .o_sum(n_sum), .o_sat(n_sat), .o_valid(n_ovalid), .i_ready(n_irdy));

  vec_sum_pipe #(.BIT_WIDTH(8), .LENGTH(5), .REG_STRIDE(2)) u_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_vec(q_vec), .i_last(q_last), .i_valid(q_ivalid),
    .o_ready(q_ordy), .o_sum(q_sum), .o_sat(q_sat), .o_valid(q_ovalid), .i_ready(q_irdy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_main(input int v);
    for (int i = 0; i < 32; i++) m_vec[i] = 8'(v);
  endtask

  // ---------------- behavioural model of the main instance ----------------
  typedef struct { longint sum; bit sat; } exp_t;
  exp_t   exp_q [$];
  longint got [$];
  longint m_acc = 0;
  bit     m_gsat = 1'b0;

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = longint'(1) << ACC_W;
    v = v & (m - 1);
    if (v > AMAX) v = v - m;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc  = 0;
      m_gsat = 1'b0;
    end else begin
      check("o_ready rule", longint'(m_ordy), longint'(!m_ovalid || m_irdy));
      if (m_ovalid && m_irdy) begin
        got.push_back(longint'(m_sum));
        if (exp_q.size() == 0) begin
          check("unexpected result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result sum", longint'(m_sum), e.sum);
          check("result sat", longint'(m_sat), longint'(e.sat));
        end
      end
      if (m_ivalid && m_ordy) begin
        longint s, t;
        s = 0;
        for (int i = 0; i < 32; i++) s += longint'(m_vec[i]);
`ifdef VEC_SUM_SAT_EN
        if (!m_gsat) begin
          t = m_acc + s;
          if (t > AMAX) begin t = AMAX; m_gsat = 1'b1; end
          else if (t < AMIN) begin t = AMIN; m_gsat = 1'b1; end
          m_acc = t;
        end
`else
        t = wrap_acc(m_acc + s);
        m_acc = t;
`endif
        if (m_last) begin
          exp_q.push_back('{sum: m_acc, sat: m_gsat});
          m_acc  = 0;
          m_gsat = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, cnt, n, stall_cnt;
    longint last_sum;
    fill_main(0);
    for (int i = 0; i < 32; i++) n_vec[i] = '0;
    for (int i = 0; i < 5; i++) q_vec[i] = '0;

    repeat (3) step();
    check("reset m_sum", longint'(m_sum), 0);
    check("reset m_valid", longint'(m_ovalid), 0);
    check("reset m_sat", longint'(m_sat), 0);
    check("reset m_ready", longint'(m_ordy), 1);
    check("reset n_outputs", longint'({n_ovalid, n_sat, n_sum}), 0);
    check("reset q_outputs", longint'({q_ovalid, q_sat, q_sum}), 0);
    check("reset n/q ready", longint'({n_ordy, q_ordy}), 3);
    rst_n = 1'b1;
    step();

    // single vector of 32 x 127, latency P+1 = 6
    fill_main(127); m_last = 1'b1; m_ivalid = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      m_ivalid = 1'b0;
      if (m_ovalid) begin lat = c; break; end
    end
    check("latency L32", lat, 6);
    check("sum 32x127", longint'(m_sum), 4064);
    step();

    // group of four 32 x -128 vectors, one result
    fill_main(-128);
    for (int b = 0; b < 4; b++) begin
      m_last = (b == 3); m_ivalid = 1'b1;
      step();
    end
    m_ivalid = 1'b0; m_last = 1'b0;
    cnt = 0; last_sum = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_ovalid) begin cnt++; last_sum = longint'(m_sum); end
      step();
    end
    check("group result count", cnt, 1);
    check("group sum", last_sum, -16384);

    // stream 1..20 with i_ready low for 10 cycles
    got.delete();
    n = 1; stall_cnt = 0; m_last = 1'b1;
    for (int cyc = 0; cyc < 100 && got.size() < 20; cyc++) begin
      m_irdy   = !(cyc >= 8 && cyc < 18);
      m_ivalid = (n <= 20);
      fill_main(n);
      @(negedge clk);
      if (m_ivalid && m_ordy) n++;
      if (!m_ordy) stall_cnt++;
      step();
    end
    m_ivalid = 1'b0; m_irdy = 1'b1;
    check("stall ready-low cycles", stall_cnt, 10);
    check("stream count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) check("stream sum", got[i], 32 * (i + 1));
    repeat (3) step();

    // LENGTH=5, REG_STRIDE=2: latency 3
    for (int i = 0; i < 5; i++) q_vec[i] = 8'(i + 1);
    q_last = 1'b1; q_ivalid = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      q_ivalid = 1'b0;
      if (q_ovalid) begin lat = c; break; end
    end
    check("latency L5", lat, 3);
    check("sum L5", longint'(q_sum), 15);

    // 14-bit accumulator, group of five 32 x 127
    for (int i = 0; i < 32; i++) n_vec[i] = 8'sd127;
    for (int b = 0; b < 5; b++) begin
      n_last = (b == 4); n_ivalid = 1'b1;
      step();
    end
    n_ivalid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (n_ovalid) begin lat = c; break; end
      step();
    end
    check("narrow result seen", longint'(lat != 0), 1);
`ifdef VEC_SUM_SAT_EN
    check("narrow sum", longint'(n_sum), 8191);
    check("narrow sat", longint'(n_sat), 1);
`else
    check("narrow sum", longint'(n_sum), 3936);
    check("narrow sat", longint'(n_sat), 0);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      m_ivalid = ($urandom_range(0, 3) != 0);
      m_last   = ($urandom_range(0, 2) == 0);
      m_irdy   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 32; i++) m_vec[i] = 8'($urandom);
      step();
    end
    m_ivalid = 1'b0; m_irdy = 1'b1;
    repeat (20) step();
    check("drain empty", exp_q.size(), 0);

    // reset in the middle of a group
    fill_main(5); m_last = 1'b0; m_ivalid = 1'b1;
    repeat (2) step();
    m_ivalid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("mid-reset m_sum", longint'(m_sum), 0);
    check("mid-reset m_valid", longint'(m_ovalid), 0);
    check("mid-reset m_sat", longint'(m_sat), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    fill_main(1); m_last = 1'b1; m_ivalid = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      m_ivalid = 1'b0;
      if (m_ovalid) begin lat = c; break; end
    end
    check("post-reset latency", lat, 6);
    check("post-reset sum", longint'(m_sum), 32);
    repeat (3) step();
    check("final empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
